float_result_buffer: RTL and testbench
======================================

# float_result_buffer

Downstream stage of `float_alu`: consumes its `valid_out`/`result`/`flags` stream and drives its `ready_in` backpressure. Results and per-op exception flags go into a small FIFO for a slower consumer, such as a register-file writeback or bus reader. A sticky IEEE-754 exception register (XZOUI) accumulates flags across operations until software clears it.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `WIDTH`, 32, result width; covers single and double-low-word results.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  from `float_alu.valid_out`.
- `in_ready`  out  1  to `float_alu.ready_in`.
- `in_result`  in  WIDTH  from `float_alu.result`.
- `in_flags`  in  5  from `float_alu.flags`, bit order {X invalid, Z div-by-zero, O overflow, U underflow, I inexact} (bit 4..0).
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts head.
- `out_result`  out  WIDTH  head result.
- `out_flags`  out  5  head flags.
- `count`  out  $clog2(DEPTH)+1  occupied entries.
- `sticky_flags`  out  5  OR of flags of all accepted results since the last clear/reset.
- `sticky_clr`  in  1  one-cycle clear of `sticky_flags`.

## Operation
- Push when `in_valid && in_ready`. Pop when `out_valid && out_ready`.
- `in_ready = (count != DEPTH)`. It depends only on registered state, with no combinational path from `out_ready`.
- `out_valid = (count != 0)`. `out_result`/`out_flags` show the entry at the read pointer.
- Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH naturally.
- `count` update per cycle:
  - +1 on push only.
  - −1 on pop only.
  - unchanged on push+pop, or on neither.
- Full with `out_ready=1`: pop occurs, push does not, because `in_ready` was already 0. `in_ready` rises the next cycle.
- Empty with `in_valid=1`: push occurs, no bypass. Data is visible the next cycle.
- Sticky register:
  - On push, `sticky_flags <= sticky_flags | in_flags`.
  - On `sticky_clr` without push, `sticky_flags <= 0`.
  - On `sticky_clr` with push in the same cycle, `sticky_flags <= in_flags`. The clear applies first, then the new op's flags.
- Flags are stored verbatim per entry. The buffer never interprets or alters the result bits.

## Timing
- Reset (async assert, sync release): pointers and `count` = 0, `sticky_flags` = 0, `in_ready` = 1, `out_valid` = 0. `out_result`/`out_flags` read a don't-care entry while `out_valid` = 0.
- Storage RAM is not reset.
- Latency: a push at edge N gives `out_valid` = 1 after edge N. The entry is poppable at edge N+1.
- Throughput: one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- `sticky_flags` updates at the same edge as the push. It reflects the pushed op one cycle after `in_valid` is sampled.
- Reset mid-operation: all entries are discarded immediately on `rst` assertion. `float_alu` must be reset together with this block; no in-flight result is preserved.
- Inputs are sampled only when `in_ready` = 1. Holding `in_valid` with changing data while `in_ready` = 0 is the producer's fault. No error flag is raised.

## Structure
- Shared package `float_alu_pkg`: `FLAG_W = 5` and flag bit indices `FLAG_NV=4, FLAG_DZ=3, FLAG_OF=2, FLAG_UF=1, FLAG_NX=0`, reused by `float_alu`.
- One sub-module, `sync_fifo`: parameterized width (WIDTH+5) and depth, with pointers, count, full/empty.
- The top level adds only the sticky register and port mapping.

## Test plan
- Single pass: push `0x423AC000` with flags `00000`, `out_ready` = 1. Required:
  - `out_valid` = 1 next cycle with `0x423AC000` / `00000`.
  - `count` goes 0→1→0.
  - `sticky_flags` stays 0.
- Flag accumulation: push `0x7F800000` with flags `00101`, then `0x7FC00000` with `10000`. Required: `sticky_flags` = `00101`, then `10101`. Per-entry flags pop unchanged, in order.
- Full/backpressure: `out_ready` = 0, push 4 results `0x3CA3D70B`, `0x3CA3D70A`, `0xC32B8000`, `0x4108A2C0`. Required:
  - `in_ready` = 0 after the 4th push.
  - A held 5th `0x00000000` is not accepted.
  - After `out_ready` = 1, pops occur in FIFO order, then the 5th is accepted.
- Simultaneous push+pop at `count` = 2 over 8 cycles. Required:
  - `count` stays 2.
  - Output sequence matches input order across pointer wrap.
- Clear race: `sticky_flags` = `00011`, then assert `sticky_clr` in the same cycle as a push with flags `00100`. Required: `sticky_flags` = `00100`.
- Mid-operation reset at `count` = 3. Required:
  - `count` = 0, `out_valid` = 0, `in_ready` = 1, `sticky_flags` = 0 immediately.
  - After release, the next push appears first.

Source files
------------

// File: rtl/float_alu_pkg.sv
// Shared definitions for the float_alu datapath and its downstream stages.
// Flag vectors are ordered {NV, DZ, OF, UF, NX} from bit 4 down to bit 0.
package float_alu_pkg;

  localparam int FLAG_W  = 5;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty status and an occupancy count.
// The ready/valid status comes from the registered count only, so there is
// no combinational path from the pop request to the full flag.
module sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_req,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop_req,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign push     = push_req && !full;
  assign pop      = pop_req && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks the push/pop balance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/float_result_buffer.sv
// Buffers float_alu results with their per-op exception flags for a slower
// consumer, and accumulates a sticky copy of every accepted op's flags.
module float_result_buffer
  import float_alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_result,
  input  logic [FLAG_W-1:0]        in_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic [FLAG_W-1:0]        out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic [FLAG_W-1:0]        sticky_flags,
  input  logic                     sticky_clr
);

  logic                    fifo_full;
  logic                    fifo_empty;
  logic [WIDTH+FLAG_W-1:0] head_entry;
  logic                    push;

  assign in_ready   = !fifo_full;
  assign out_valid  = !fifo_empty;
  assign push       = in_valid && in_ready;
  assign out_result = head_entry[WIDTH+FLAG_W-1:FLAG_W];
  assign out_flags  = head_entry[FLAG_W-1:0];

  sync_fifo #(
    .WIDTH (WIDTH + FLAG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_req  (in_valid),
    .push_data ({in_result, in_flags}),
    .pop_req   (out_ready),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  // Sticky flags: a clear takes effect before the same-cycle push's flags are merged in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= '0;
    end else if (push) begin
      sticky_flags <= (sticky_clr ? '0 : sticky_flags) | in_flags;
    end else if (sticky_clr) begin
      sticky_flags <= '0;
    end
  end

endmodule

// File: tb/tb_float_result_buffer.sv
// Directed bench for float_result_buffer: a reference model of occupancy and
// sticky flags plus a scoreboard queue of expected {result, flags} entries.
module tb_float_result_buffer;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [4:0]       in_flags;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [4:0]       out_flags;
  logic [2:0]       count;
  logic [4:0]       sticky_flags;
  logic             sticky_clr;

  int               checks = 0;
  int               errors = 0;
  int               modelCount = 0;
  logic [4:0]       modelSticky = '0;
  logic [36:0]      scoreboard[$];

  float_result_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .count        (count),
    .sticky_flags (sticky_flags),
    .sticky_clr   (sticky_clr)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the model before the next edge.
  task automatic checkOutput();
    logic [36:0] head;
    checkVal("count", 64'(count), 64'(modelCount));
    checkVal("in_ready", 64'(in_ready), 64'(modelCount != DEPTH));
    checkVal("out_valid", 64'(out_valid), 64'(modelCount != 0));
    checkVal("sticky_flags", 64'(sticky_flags), 64'(modelSticky));
    if (modelCount != 0 && scoreboard.size() != 0) begin
      head = scoreboard[0];
      checkVal("out_result", 64'(out_result), 64'(head[36:5]));
      checkVal("out_flags", 64'(out_flags), 64'(head[4:0]));
    end
  endtask

  // Drive one cycle of stimulus, check, then advance the model across the edge.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [4:0] f,
                               input logic r, input logic clr);
    logic doPush;
    logic doPop;
    in_valid   = v;
    in_result  = d;
    in_flags   = f;
    out_ready  = r;
    sticky_clr = clr;
    #1;
    checkOutput();
    doPush = v && (modelCount != DEPTH);
    doPop  = r && (modelCount != 0);
    if (doPush) modelSticky = (clr ? 5'b0 : modelSticky) | f;
    else if (clr) modelSticky = 5'b0;
    if (doPop && scoreboard.size() != 0) void'(scoreboard.pop_front());
    if (doPush) scoreboard.push_back({d, f});
    modelCount = modelCount + (doPush ? 1 : 0) - (doPop ? 1 : 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && modelCount != 0; i++) begin
      applyStimulus(1'b0, 32'h0, 5'b0, 1'b1, 1'b0);
    end
    checkVal("drained", 64'(modelCount), 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_result  = '0;
    in_flags   = '0;
    out_ready  = 1'b0;
    sticky_clr = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] reset state");
    checkOutput();

    $display("[TB] single pass");
    applyStimulus(1'b1, 32'h423AC000, 5'b00000, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 5'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 5'b0, 1'b0, 1'b0);

    $display("[TB] flag accumulation");
    applyStimulus(1'b1, 32'h7F800000, 5'b00101, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h7FC00000, 5'b10000, 1'b0, 1'b0);
    checkVal("sticky_acc", 64'(sticky_flags), 64'h15);
    drain();

    $display("[TB] full and backpressure");
    applyStimulus(1'b1, 32'h3CA3D70B, 5'b00001, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h3CA3D70A, 5'b00001, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hC32B8000, 5'b00000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h4108A2C0, 5'b00001, 1'b0, 1'b0);
    checkVal("full_in_ready", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 32'h00000000, 5'b00000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00000000, 5'b00000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00000000, 5'b00000, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h00000000, 5'b00000, 1'b1, 1'b0);
    drain();

    $display("[TB] simultaneous push and pop across wrap");
    applyStimulus(1'b1, 32'hA0000000, 5'b00010, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hA0000001, 5'b01000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'hB0000000 + 32'(i), 5'(i), 1'b1, 1'b0);
      checkVal("steady_count", 64'(count), 64'd2);
    end
    drain();

    $display("[TB] clear race");
    applyStimulus(1'b0, 32'h0, 5'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h3F800000, 5'b00011, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h40000000, 5'b00100, 1'b0, 1'b1);
    checkVal("clear_race", 64'(sticky_flags), 64'h04);
    drain();

    $display("[TB] mid-operation reset");
    applyStimulus(1'b1, 32'h11111111, 5'b10000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h22222222, 5'b01000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h33333333, 5'b00100, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    scoreboard.delete();
    modelCount  = 0;
    modelSticky = '0;
    checkOutput();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 32'h44444444, 5'b00001, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 5'b0, 1'b1, 1'b0);
    checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
